uart_rx_param: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8N1 receiver in the UART submodule. It adds configurable data width, parity, stop-bit count and oversample ratio, with 3-sample majority voting at each bit centre. It reports parity, framing, overrun and break errors per frame. It sits between the board rx pin and the Ethernet-side command/data logic, clocked from clk_50m, with a baud-rate oversample enable supplied by the shared baud generator.

---
 rtl/uart_rx_param.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 3-sample majority voting.
//
// Each bit is sampled at the three clken ticks around its centre and the
// majority of those samples is taken as the bit value. Every completed frame
// reports parity, framing, overrun and break errors.
//
// Ports:
//   clk_50m    - system clock
//   rst_n      - asynchronous active-low reset (deasserted synchronously inside)
//   clken      - oversample tick, OVERSAMPLE ticks per bit period
//   rx         - asynchronous serial input, idle high
//   rdy_clr    - clears rdy (a frame completing in the same cycle wins)
//   rdy        - sticky "frame received" flag
//   data       - last received data word
//   parity_err - parity mismatch on the last frame
//   frame_err  - a stop bit was sampled low on the last frame
//   overrun    - the last frame completed while rdy was still set
//   break_det  - the last frame was all zero, including parity and stop bits
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 clken,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LO    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_HI    = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    // Reset: asserts asynchronously, releases two clocks after rst_n rises.
    logic [1:0] rst_pipe;
    logic       rst_int_n;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_int_n = rst_pipe[1];

    // rx synchroniser, preset to the idle level.
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;

    always_ff @(posedge clk_50m or negedge rst_int_n) begin
        if (!rst_int_n) sync <= '1;
        else            sync <= {sync[SYNC_STAGES-2:0], rx};
    end
    assign rx_s = sync[SYNC_STAGES-1];

    state_t                 state, state_next;
    logic [CW-1:0]          cnt, cnt_next;
    logic [IW-1:0]          idx, idx_next;
    logic                   stop_idx, stop_idx_next;
    logic [1:0]             samp, samp_next;
    logic [DATA_BITS-1:0]   shift, shift_next;
    logic                   perr_p, perr_next;
    logic                   ferr_p, ferr_next;
    logic                   brk_p, brk_next;
    logic                   maj, resolve, wrap, done;

    // The third sample is the live rx_s on the resolve tick.
    assign maj     = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign resolve = clken && (cnt == CNT_HI);
    assign wrap    = clken && (cnt == CNT_MAX);

    always_ff @(posedge clk_50m or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            samp     <= 2'b00;
            shift    <= '0;
            perr_p   <= 1'b0;
            ferr_p   <= 1'b0;
            brk_p    <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            idx      <= idx_next;
            stop_idx <= stop_idx_next;
            samp     <= samp_next;
            shift    <= shift_next;
            perr_p   <= perr_next;
            ferr_p   <= ferr_next;
            brk_p    <= brk_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        idx_next      = idx;
        stop_idx_next = stop_idx;
        samp_next     = samp;
        shift_next    = shift;
        perr_next     = perr_p;
        ferr_next     = ferr_p;
        brk_next      = brk_p;
        done          = 1'b0;

        if (clken) begin
            if (cnt == CNT_LO)  samp_next[0] = rx_s;
            if (cnt == CNT_MID) samp_next[1] = rx_s;
            // Power-of-two OVERSAMPLE lets the counter wrap on its own.
            if (state != S_IDLE && state != S_BREAK) cnt_next = cnt + CNT_ONE;
        end

        case (state)
            S_IDLE: begin
                if (clken && !rx_s) begin
                    state_next = S_START;
                    cnt_next   = CNT_ONE;
                    perr_next  = 1'b0;
                    ferr_next  = 1'b0;
                    brk_next   = 1'b1;
                end
            end
            S_START: begin
                if (resolve && maj) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (wrap) begin
                    state_next = S_DATA;
                    idx_next   = '0;
                end
            end
            S_DATA: begin
                if (resolve) begin
                    shift_next[idx] = maj;
                    if (maj) brk_next = 1'b0;
                end
                if (wrap) begin
                    if (idx == LAST_BIT) begin
                        state_next    = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_idx_next = 1'b0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (resolve) begin
                    if (maj != ((^shift) ^ ODD)) perr_next = 1'b1;
                    if (maj) brk_next = 1'b0;
                end
                if (wrap) begin
                    state_next    = S_STOP;
                    stop_idx_next = 1'b0;
                end
            end
            S_STOP: begin
                if (resolve) begin
                    if (!maj) ferr_next = 1'b1;
                    else      brk_next  = 1'b0;
                    // Finish at the centre of the last stop bit so an early
                    // next start bit is not missed.
                    if (stop_idx == LAST_STOP) begin
                        done       = 1'b1;
                        cnt_next   = '0;
                        state_next = brk_next ? S_BREAK : S_IDLE;
                    end
                end else if (wrap) begin
                    stop_idx_next = 1'b1;
                end
            end
            S_BREAK: begin
                if (clken && rx_s) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Frame results. A completing frame beats a simultaneous rdy_clr, and
    // overrun sees the value rdy had before either took effect.
    always_ff @(posedge clk_50m or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rdy        <= 1'b0;
            data       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else if (done) begin
            rdy        <= 1'b1;
            overrun    <= rdy;
            data       <= shift;
            parity_err <= perr_next;
            frame_err  <= ferr_next;
            break_det  <= brk_next;
        end else if (rdy_clr) begin
            rdy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance (defaults) and a 7E2 instance.
// clken fires every second clock; rx changes only on the falling clock edge
// right after a clken cycle, so each bench "tick" is one clken period.
module tb_uart_rx_param;
    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       clken   = 1'b0;
    logic       rdy_clr = 1'b0;
    logic       rx0     = 1'b1;
    logic       rx1     = 1'b1;

    logic       rdy0, pe0, fe0, ov0, bk0;
    logic [7:0] data0;
    logic       rdy1, pe1, fe1, ov1, bk1;
    logic [6:0] data1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    uart_rx_param dut0 (
        .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .rx(rx0), .rdy_clr(rdy_clr),
        .rdy(rdy0), .data(data0), .parity_err(pe0), .frame_err(fe0),
        .overrun(ov0), .break_det(bk0)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .rx(rx1), .rdy_clr(rdy_clr),
        .rdy(rdy1), .data(data1), .parity_err(pe1), .frame_err(fe1),
        .overrun(ov1), .break_det(bk1)
    );

    always #10 clk_50m = ~clk_50m;

    always @(negedge clk_50m) begin
        cyc   = cyc + 1;
        clken = (cyc % 2 == 0);
    end

    initial begin
        #4_000_000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic r, input logic [7:0] d,
                        input logic pe, input logic fe, input logic ov, input logic bk);
        check({tag, ".rdy"},        16'(rdy0),  16'(r));
        check({tag, ".data"},       16'(data0), 16'(d));
        check({tag, ".parity_err"}, 16'(pe0),   16'(pe));
        check({tag, ".frame_err"},  16'(fe0),   16'(fe));
        check({tag, ".overrun"},    16'(ov0),   16'(ov));
        check({tag, ".break_det"},  16'(bk0),   16'(bk));
        $display("%s: rdy=%0b data=%02h pe=%0b fe=%0b ov=%0b bk=%0b", tag, rdy0, data0, pe0, fe0, ov0, bk0);
    endtask

    // Drive one rx line to v for n clken ticks.
    task automatic hold(input int which, input logic v, input int n);
        if (which == 0) rx0 = v;
        else            rx1 = v;
        for (int i = 0; i < n; i++) begin
            do @(posedge clk_50m); while (clken !== 1'b1);
            @(negedge clk_50m);
        end
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
    endtask

    // 8N1 frame on rx0. gbit (0..7) gets a one-tick inverted glitch at gtick.
    // clr_done raises rdy_clr exactly in the cycle the frame completes: the
    // centre sample of the stop bit is resolved on its 11th tick.
    task automatic send0(input logic [7:0] d, input logic stop_v, input int gbit,
                         input int gtick, input bit clr_done);
        hold(0, 1'b0, 16);
        for (int b = 0; b < 8; b++) begin
            if (b == gbit) begin
                hold(0, d[b], gtick);
                hold(0, ~d[b], 1);
                hold(0, d[b], 15 - gtick);
            end else begin
                hold(0, d[b], 16);
            end
        end
        if (clr_done) begin
            hold(0, stop_v, 10);
            @(negedge clk_50m);
            rdy_clr = 1'b1;
            @(negedge clk_50m);
            rdy_clr = 1'b0;
            hold(0, stop_v, 5);
        end else begin
            hold(0, stop_v, 16);
        end
        hold(0, 1'b1, 16);
    endtask

    task automatic send1(input logic [6:0] d, input logic par, input logic s1, input logic s2);
        hold(1, 1'b0, 16);
        for (int b = 0; b < 7; b++) hold(1, d[b], 16);
        hold(1, par, 16);
        hold(1, s1, 16);
        hold(1, s2, 16);
        hold(1, 1'b1, 16);
    endtask

    typedef struct {
        logic [6:0] d;
        logic       par;
        logic       s1;
        logic       s2;
        logic [6:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_bk;
    } vec_t;

    vec_t vecs [8];

    // Reference state for the random phase.
    logic       model_rdy;
    logic [7:0] rd;
    logic       rstop;
    int         rgbit, rgtick;
    bit         rpre, rdone;
    logic       exp_ov, exp_bk;

    initial begin
        // 7E2 table: data, parity bit sent, stop1, stop2 -> data, pe, fe, bk
        vecs[0] = '{7'h41, 1'b1, 1'b1, 1'b1, 7'h41, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{7'h41, 1'b0, 1'b1, 1'b1, 7'h41, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{7'h2A, 1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{7'h2A, 1'b1, 1'b1, 1'b1, 7'h2A, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{7'h7F, 1'b0, 1'b1, 1'b1, 7'h7F, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{7'h00, 1'b0, 1'b0, 1'b1, 7'h00, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{7'h13, 1'b1, 1'b1, 1'b1, 7'h13, 1'b0, 1'b0, 1'b0};

        repeat (5) @(negedge clk_50m);
        chk0("in_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        hold(0, 1'b1, 20);
        chk0("after_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic 8N1 frames.
        send0(8'h55, 1'b1, -1, 0, 1'b0);
        chk0("frame_55", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_clr();
        check("clr.rdy", 16'(rdy0), 16'd0);
        send0(8'hA3, 1'b1, -1, 0, 1'b0);
        chk0("frame_a3", 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_clr();

        // False start: 5 low ticks are gone before the centre samples.
        hold(0, 1'b0, 5);
        hold(0, 1'b1, 30);
        chk0("false_start", 1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);

        // One-tick glitch on the centre of data bit 3 is voted out.
        send0(8'hFF, 1'b1, 3, 8, 1'b0);
        chk0("glitch_ff", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

        // Overrun, and rdy_clr coinciding with completion.
        pulse_clr();
        send0(8'h12, 1'b1, -1, 0, 1'b0);
        chk0("ovr_12", 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
        send0(8'h34, 1'b1, -1, 0, 1'b0);
        chk0("ovr_34", 1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
        send0(8'h56, 1'b1, -1, 0, 1'b1);
        chk0("clr_at_done", 1'b1, 8'h56, 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_clr();
        chk0("clr_keeps_flags", 1'b0, 8'h56, 1'b0, 1'b0, 1'b1, 1'b0);
        send0(8'h9C, 1'b1, -1, 0, 1'b0);
        chk0("no_ovr_9c", 1'b1, 8'h9C, 1'b0, 1'b0, 1'b0, 1'b0);

        // Break: 12 bit times low.
        pulse_clr();
        hold(0, 1'b0, 192);
        chk0("break", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_clr();
        hold(0, 1'b0, 192);
        check("break_hold.rdy", 16'(rdy0), 16'd0);
        hold(0, 1'b1, 16);
        send0(8'h7E, 1'b1, -1, 0, 1'b0);
        chk0("after_break_7e", 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of data bit 2.
        hold(0, 1'b0, 16);
        hold(0, 1'b1, 16);
        hold(0, 1'b0, 20);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50m);
        chk0("mid_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        hold(0, 1'b1, 20);
        chk0("post_reset_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send0(8'hC3, 1'b1, -1, 0, 1'b0);
        chk0("post_reset_c3", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised 8N1 frames against the reference model.
        model_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rd     = 8'($urandom);
            rstop  = ($urandom_range(0, 3) != 0);
            rgbit  = int'($urandom_range(0, 9));
            rgtick = int'($urandom_range(0, 15));
            rpre   = ($urandom_range(0, 1) == 1);
            rdone  = ($urandom_range(0, 3) == 0);
            if (rpre) begin
                pulse_clr();
                model_rdy = 1'b0;
            end
            exp_ov = model_rdy;
            exp_bk = (rd == 8'h00) && !rstop;
            send0(rd, rstop, rgbit, rgtick, rdone);
            model_rdy = 1'b1;
            chk0($sformatf("rand%0d", i), 1'b1, rd, 1'b0, !rstop, exp_ov, exp_bk);
        end

        // 7E2 table.
        for (int i = 0; i < 8; i++) begin
            pulse_clr();
            send1(vecs[i].d, vecs[i].par, vecs[i].s1, vecs[i].s2);
            check($sformatf("v%0d.rdy", i),        16'(rdy1),  16'd1);
            check($sformatf("v%0d.data", i),       16'(data1), 16'(vecs[i].exp_d));
            check($sformatf("v%0d.parity_err", i), 16'(pe1),   16'(vecs[i].exp_pe));
            check($sformatf("v%0d.frame_err", i),  16'(fe1),   16'(vecs[i].exp_fe));
            check($sformatf("v%0d.break_det", i),  16'(bk1),   16'(vecs[i].exp_bk));
            check($sformatf("v%0d.overrun", i),    16'(ov1),   16'd0);
            $display("v%0d: data=%02h pe=%0b fe=%0b bk=%0b", i, data1, pe1, fe1, bk1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
